// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline sequencer.
package pipe_ctrl_pkg;

   // Sequencer states: normal issue, then the three phases of a UART byte send.
   typedef enum logic [1:0] {
      RUN     = 2'd0,
      TX_WAIT = 2'd1,
      TX_BUSY = 2'd2,
      TX_DONE = 2'd3
   } pipe_state_e;

   localparam int TIMEOUT_DEF = 8191;
   localparam int CNT_W_DEF   = 32;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter: counts qualifying cycles, sticks at all-ones.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] r_q;
   logic         w_full;

   assign w_full = &r_q;

   // Count one per inc cycle, holding once every bit is set.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= '0;
      end else if (inc && !w_full) begin
         r_q <= r_q + 1'b1;
      end
   end

   assign q = r_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: maps hazard and UART-store events onto per-stage
// enable/flush/bubble controls, runs the UART TX byte handshake, and keeps
// saturating stall/flush debug counters.
//
// TX handshake: the UART accepts a byte on any cycle where tx_start_o is
// high; tx_start_o is only raised while tx_busy_i is low, lasts exactly one
// cycle, and is never repeated for the same store. Completion is a rise of
// tx_busy_i after the start followed by its fall.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld_use_i,
   input  logic             br_taken_i,
   input  logic             uart_wr_i,
   input  logic             tx_busy_i,
   output logic             tx_start_o,
   output logic             t_byte_o,
   output logic             pc_en_o,
   output logic             ir_d_en_o,
   output logic             ir_e_en_o,
   output logic             flush_d_o,
   output logic             bubble_e_o,
   output logic             tx_timeout_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o,
   output pipe_state_e      state_o
);

   localparam int              TO_W    = $clog2(TIMEOUT + 1);
   // r_to_cnt holds the number of stall cycles already completed, so the
   // current cycle is stall cycle r_to_cnt+1; the TIMEOUT-th cycle is the last.
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   pipe_state_e     r_state;
   pipe_state_e     w_state_nxt;
   logic [TO_W-1:0] r_to_cnt;
   logic            r_seen_busy;
   logic            r_tx_timeout;

   logic            w_to_hit;
   logic            w_to_clr;
   logic            w_to_set;
   logic            w_seen_clr;
   logic            w_in_tx;

   logic            w_pc_en;
   logic            w_ir_d_en;
   logic            w_ir_e_en;
   logic            w_flush_d;
   logic            w_bubble_e;
   logic            w_t_byte;
   logic            w_tx_start;

   assign w_in_tx  = (r_state == TX_WAIT) || (r_state == TX_BUSY);
   assign w_to_hit = w_in_tx && (r_to_cnt == TO_LAST);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and control decode; RUN decodes straight from the hazard inputs.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_en     = 1'b1;
      w_ir_d_en   = 1'b1;
      w_ir_e_en   = 1'b1;
      w_flush_d   = 1'b0;
      w_bubble_e  = 1'b0;
      w_t_byte    = 1'b0;
      w_tx_start  = 1'b0;
      w_to_clr    = 1'b0;
      w_to_set    = 1'b0;
      w_seen_clr  = 1'b0;

      unique case (r_state)
         RUN: begin
            if (uart_wr_i) begin
               w_pc_en     = 1'b0;
               w_ir_d_en   = 1'b0;
               w_ir_e_en   = 1'b0;
               w_t_byte    = 1'b1;
               w_to_clr    = 1'b1;
               w_state_nxt = TX_WAIT;
            end else if (br_taken_i) begin
               // A taken branch discards a dependent load-use victim too,
               // so this cycle is a flush and not a stall.
               w_flush_d  = 1'b1;
               w_bubble_e = 1'b1;
            end else if (ld_use_i) begin
               w_pc_en    = 1'b0;
               w_ir_d_en  = 1'b0;
               w_bubble_e = 1'b1;
            end
         end
         TX_WAIT: begin
            w_pc_en   = 1'b0;
            w_ir_d_en = 1'b0;
            w_ir_e_en = 1'b0;
            w_t_byte  = 1'b1;
            // Timeout wins so a stuck transmitter never receives a start.
            if (w_to_hit) begin
               w_to_set    = 1'b1;
               w_state_nxt = TX_DONE;
            end else if (!tx_busy_i) begin
               w_tx_start  = 1'b1;
               w_seen_clr  = 1'b1;
               w_state_nxt = TX_BUSY;
            end
         end
         TX_BUSY: begin
            w_pc_en   = 1'b0;
            w_ir_d_en = 1'b0;
            w_ir_e_en = 1'b0;
            w_t_byte  = 1'b1;
            if (w_to_hit) begin
               w_to_set    = 1'b1;
               w_state_nxt = TX_DONE;
            end else if (r_seen_busy && !tx_busy_i) begin
               w_state_nxt = TX_DONE;
            end
         end
         TX_DONE: begin
            // Release cycle: the store leaves E; hazard inputs are ignored.
            w_state_nxt = RUN;
         end
         default: begin
            w_state_nxt = RUN;
         end
      endcase

      if (rst) begin
         w_pc_en    = 1'b0;
         w_ir_d_en  = 1'b0;
         w_ir_e_en  = 1'b0;
         w_flush_d  = 1'b1;
         w_bubble_e = 1'b1;
         w_t_byte   = 1'b0;
         w_tx_start = 1'b0;
      end
   end

   // TX stall timeout counter: cleared on entry to TX_WAIT, runs while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_to_cnt <= '0;
      end else if (w_to_clr) begin
         r_to_cnt <= '0;
      end else if (w_in_tx && !w_to_hit) begin
         r_to_cnt <= r_to_cnt + 1'b1;
      end
   end

   // Remember that the transmitter went busy after our start pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_seen_busy <= 1'b0;
      end else if (w_seen_clr) begin
         r_seen_busy <= 1'b0;
      end else if ((r_state == TX_BUSY) && tx_busy_i) begin
         r_seen_busy <= 1'b1;
      end
   end

   // Sticky timeout flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_timeout <= 1'b0;
      end else if (w_to_set) begin
         r_tx_timeout <= 1'b1;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (~w_pc_en),
      .q   (stall_cnt_o)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .inc (w_flush_d),
      .q   (flush_cnt_o)
   );

   assign pc_en_o      = w_pc_en;
   assign ir_d_en_o    = w_ir_d_en;
   assign ir_e_en_o    = w_ir_e_en;
   assign flush_d_o    = w_flush_d;
   assign bubble_e_o   = w_bubble_e;
   assign t_byte_o     = w_t_byte;
   assign tx_start_o   = w_tx_start;
   assign tx_timeout_o = r_tx_timeout;
   assign state_o      = r_state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: reset, hazards, UART send, timeout,
// reset during a send, and counter saturation (4-bit counters).
module tb_pipe_ctrl;
   import pipe_ctrl_pkg::*;

   localparam int TO  = 20;
   localparam int CW  = 4;

   // Control bundle: {pc_en, ir_d_en, ir_e_en, flush_d, bubble_e, t_byte, tx_start}
   localparam logic [6:0] CTL_RST   = 7'b000_11_0_0;
   localparam logic [6:0] CTL_RUN   = 7'b111_00_0_0;
   localparam logic [6:0] CTL_LD    = 7'b001_01_0_0;
   localparam logic [6:0] CTL_BR    = 7'b111_11_0_0;
   localparam logic [6:0] CTL_FRZ   = 7'b000_00_1_0;
   localparam logic [6:0] CTL_START = 7'b000_00_1_1;

   logic clk = 1'b0;
   logic rst;
   logic ld_use_i, br_taken_i, uart_wr_i, tx_busy_i;
   logic tx_start_o, t_byte_o, pc_en_o, ir_d_en_o, ir_e_en_o;
   logic flush_d_o, bubble_e_o, tx_timeout_o;
   logic [CW-1:0] stall_cnt_o, flush_cnt_o;
   pipe_state_e state_o;
   logic [6:0] ctl;

   int n_assert = 0;
   int n_fail   = 0;

   assign ctl = {pc_en_o, ir_d_en_o, ir_e_en_o, flush_d_o, bubble_e_o, t_byte_o, tx_start_o};

   always #5 clk = ~clk;

   pipe_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk          (clk),
      .rst          (rst),
      .ld_use_i     (ld_use_i),
      .br_taken_i   (br_taken_i),
      .uart_wr_i    (uart_wr_i),
      .tx_busy_i    (tx_busy_i),
      .tx_start_o   (tx_start_o),
      .t_byte_o     (t_byte_o),
      .pc_en_o      (pc_en_o),
      .ir_d_en_o    (ir_d_en_o),
      .ir_e_en_o    (ir_e_en_o),
      .flush_d_o    (flush_d_o),
      .bubble_e_o   (bubble_e_o),
      .tx_timeout_o (tx_timeout_o),
      .stall_cnt_o  (stall_cnt_o),
      .flush_cnt_o  (flush_cnt_o),
      .state_o      (state_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ld_use_i   = 1'b0;
      br_taken_i = 1'b0;
      uart_wr_i  = 1'b0;
      tx_busy_i  = 1'b0;
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      idle_inputs();
      repeat (3) tick();
      chk("rst_ctl", 32'(ctl), 32'(CTL_RST));
      chk("rst_state", 32'(state_o), 32'(RUN));
      rst = 1'b0;
      #1;
      chk("post_rst_ctl", 32'(ctl), 32'(CTL_RUN));
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0] exp_ctl;

      // Reset and idle.
      reset_dut();
      chk("idle_ctl", 32'(ctl), 32'(CTL_RUN));
      chk("idle_stall_cnt", 32'(stall_cnt_o), 32'd0);
      chk("idle_flush_cnt", 32'(flush_cnt_o), 32'd0);
      chk("idle_timeout", 32'(tx_timeout_o), 32'd0);

      // Load-use: one bubble cycle.
      ld_use_i = 1'b1;
      #1;
      chk("ld_ctl", 32'(ctl), 32'(CTL_LD));
      tick();
      ld_use_i = 1'b0;
      #1;
      chk("ld_after_ctl", 32'(ctl), 32'(CTL_RUN));
      chk("ld_stall_cnt", 32'(stall_cnt_o), 32'd1);
      chk("ld_flush_cnt", 32'(flush_cnt_o), 32'd0);

      // Branch together with load-use: flush only.
      reset_dut();
      br_taken_i = 1'b1;
      ld_use_i   = 1'b1;
      #1;
      chk("br_ctl", 32'(ctl), 32'(CTL_BR));
      tick();
      idle_inputs();
      #1;
      chk("br_flush_cnt", 32'(flush_cnt_o), 32'd1);
      chk("br_stall_cnt", 32'(stall_cnt_o), 32'd0);

      // UART send: busy 1 for cycles 0-4, 0 for 5-6, 1 for 7-16, 0 after.
      // Start at cycle 5, release (TX_DONE) at 18, store still asserted there.
      reset_dut();
      for (int c = 0; c < 20; c++) begin
         uart_wr_i = (c <= 18);
         tx_busy_i = (c <= 4) || (c >= 7 && c <= 16);
         #1;
         if (c == 5)        exp_ctl = CTL_START;
         else if (c <= 17)  exp_ctl = CTL_FRZ;
         else               exp_ctl = CTL_RUN;
         chk($sformatf("tx_ctl_c%0d", c), 32'(ctl), 32'(exp_ctl));
         if (c == 18) chk("tx_done_state", 32'(state_o), 32'(TX_DONE));
         tick();
      end
      idle_inputs();
      #1;
      chk("tx_end_state", 32'(state_o), 32'(RUN));
      // 18 frozen cycles saturate a 4-bit counter at 15 rather than wrapping.
      chk("tx_stall_sat", 32'(stall_cnt_o), 32'd15);
      chk("tx_flush_cnt", 32'(flush_cnt_o), 32'd0);
      chk("tx_no_timeout", 32'(tx_timeout_o), 32'd0);

      // Timeout: busy stuck high; 20 wait cycles (1-20), release at 21.
      reset_dut();
      for (int c = 0; c < 23; c++) begin
         uart_wr_i = (c == 0);
         tx_busy_i = 1'b1;
         #1;
         exp_ctl = (c <= 20) ? CTL_FRZ : CTL_RUN;
         chk($sformatf("to_ctl_c%0d", c), 32'(ctl), 32'(exp_ctl));
         chk($sformatf("to_flag_c%0d", c), 32'(tx_timeout_o), (c >= 21) ? 32'd1 : 32'd0);
         if (c == 21) chk("to_done_state", 32'(state_o), 32'(TX_DONE));
         tick();
      end
      idle_inputs();
      repeat (3) tick();
      chk("to_sticky", 32'(tx_timeout_o), 32'd1);
      reset_dut();
      chk("to_cleared", 32'(tx_timeout_o), 32'd0);

      // Reset while in TX_BUSY: straight back to RUN, no release, no start.
      uart_wr_i = 1'b1;
      tx_busy_i = 1'b0;
      tick();
      uart_wr_i = 1'b0;
      #1;
      chk("rb_start", 32'(ctl), 32'(CTL_START));
      tick();
      tx_busy_i = 1'b1;
      #1;
      chk("rb_busy_state", 32'(state_o), 32'(TX_BUSY));
      chk("rb_busy_ctl", 32'(ctl), 32'(CTL_FRZ));
      rst = 1'b1;
      #1;
      chk("rb_rst_ctl", 32'(ctl), 32'(CTL_RST));
      tick();
      rst = 1'b0;
      tx_busy_i = 1'b0;
      #1;
      chk("rb_state", 32'(state_o), 32'(RUN));
      chk("rb_ctl", 32'(ctl), 32'(CTL_RUN));
      tick();
      chk("rb_ctl2", 32'(ctl), 32'(CTL_RUN));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
